// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, PSW bit positions,
// FSM state encoding and the operation classes used by the flag logic.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADDC = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SUBC = 4'h3;
    localparam logic [3:0] OP_CMP  = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_BIC  = 4'h8;
    localparam logic [3:0] OP_MOV  = 4'h9;
    localparam logic [3:0] OP_SRA  = 4'hA;
    localparam logic [3:0] OP_RRC  = 4'hB;
    localparam logic [3:0] OP_SHL  = 4'hC;
    localparam logic [3:0] OP_SWPB = 4'hD;
    localparam logic [3:0] OP_SXT  = 4'hE;
    localparam logic [3:0] OP_RSVD = 4'hF;

    localparam int PSW_C = 0;
    localparam int PSW_Z = 1;
    localparam int PSW_N = 2;
    localparam int PSW_V = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_ARITH = 2'd0,
        CLS_LOGIC = 2'd1,
        CLS_SHIFT = 2'd2,
        CLS_KEEP  = 2'd3
    } op_cls_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SRA) || (op == OP_RRC) || (op == OP_SHL);
    endfunction

endpackage

// File: rtl/alu_flags.sv
// Next-PSW computation from a finished result; shared by the single-cycle
// path and by shift completion.
module alu_flags
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] res,
    input  logic             carry,
    input  logic             ovf,
    input  op_cls_t          cls,
    input  logic             bw,
    input  logic [3:0]       psw_in,
    output logic [3:0]       psw_out
);

    logic msb;
    logic zero;

    assign msb  = bw ? res[7] : res[WIDTH-1];
    assign zero = bw ? (res[7:0] == 8'd0) : (res == '0);

    always_comb begin
        psw_out = psw_in;
        case (cls)
            CLS_ARITH: begin
                psw_out[PSW_C] = carry;
                psw_out[PSW_V] = ovf;
                psw_out[PSW_N] = msb;
                psw_out[PSW_Z] = zero;
            end
            CLS_SHIFT: begin
                psw_out[PSW_C] = carry;
                psw_out[PSW_V] = 1'b0;
                psw_out[PSW_N] = msb;
                psw_out[PSW_Z] = zero;
            end
            // Logic-class ops keep C from the incoming PSW.
            CLS_LOGIC: begin
                psw_out[PSW_V] = 1'b0;
                psw_out[PSW_N] = msb;
                psw_out[PSW_Z] = zero;
            end
            default: psw_out = psw_in;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with byte mode and full PSW; multi-bit shifts and rotates
// advance one bit per clock under the IDLE/BUSY/DONE FSM.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             bw,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] src,
    input  logic [WIDTH-1:0] dst,
    input  logic [3:0]       psw_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       psw_out,
    output logic             wb,
    output logic [1:0]       state_dbg
);

    // Handshake: an operation transfers on a clock edge where in_valid and
    // in_ready are both high; a result transfers where out_valid and out_ready
    // are both high. Result, psw_out and wb stay constant while out_valid waits.
    localparam logic [CNT_W:0] CNT_ONE = (CNT_W + 1)'(1);

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic             bw_q, bw_d;
    logic [CNT_W:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             wc_q, wc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       psw_q, psw_d;
    logic             wb_q, wb_d;

    logic [WIDTH-1:0] b_op, sc_lane, sc_res;
    logic             cin, sc_carry, sc_ovf, sc_bw, sc_wb;
    logic [WIDTH:0]   sum_w;
    logic [8:0]       sum_b;
    op_cls_t          sc_cls;
    logic [WIDTH-1:0] sh_val;
    logic             sh_c;
    logic [WIDTH-1:0] fl_res;
    logic             fl_carry, fl_ovf, fl_bw;
    op_cls_t          fl_cls;
    logic [3:0]       fl_psw_in, fl_psw;
    logic             busy;

    always_ff @(posedge Clock) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = is_shift(op) ? S_BUSY : S_DONE;
            S_BUSY: if (cnt_q == CNT_ONE) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE) && !Reset;
        out_valid = (state_q == S_DONE);
        state_dbg = state_q;
    end

    // Subtracts add the inverted source; C=1 then means no borrow.
    always_comb begin
        b_op = src;
        cin  = 1'b0;
        case (op)
            OP_ADDC:        cin = psw_in[PSW_C];
            OP_SUB, OP_CMP: begin b_op = ~src; cin = 1'b1;           end
            OP_SUBC:        begin b_op = ~src; cin = psw_in[PSW_C]; end
            default: ;
        endcase
    end

    assign sum_w    = {1'b0, dst} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    assign sum_b    = {1'b0, dst[7:0]} + {1'b0, b_op[7:0]} + {8'd0, cin};
    assign sc_carry = bw ? sum_b[8] : sum_w[WIDTH];
    assign sc_ovf   = bw ? ((dst[7] == b_op[7]) && (sum_b[7] != dst[7]))
                         : ((dst[WIDTH-1] == b_op[WIDTH-1]) && (sum_w[WIDTH-1] != dst[WIDTH-1]));

    always_comb begin
        sc_lane = bw ? {{(WIDTH-8){1'b0}}, sum_b[7:0]} : sum_w[WIDTH-1:0];
        sc_cls  = CLS_ARITH;
        sc_bw   = bw;
        sc_wb   = 1'b1;
        case (op)
            OP_CMP:  sc_wb = 1'b0;
            OP_XOR:  begin sc_lane = dst ^ src;  sc_cls = CLS_LOGIC; end
            OP_AND:  begin sc_lane = dst & src;  sc_cls = CLS_LOGIC; end
            OP_OR:   begin sc_lane = dst | src;  sc_cls = CLS_LOGIC; end
            OP_BIC:  begin sc_lane = dst & ~src; sc_cls = CLS_LOGIC; end
            OP_MOV:  begin sc_lane = src;        sc_cls = CLS_KEEP;  end
            OP_SWPB: begin
                sc_lane       = dst;
                sc_lane[15:0] = {dst[7:0], dst[15:8]};
                sc_cls        = CLS_LOGIC;
                sc_bw         = 1'b0;
            end
            OP_SXT:  begin
                sc_lane = {{(WIDTH-8){dst[7]}}, dst[7:0]};
                sc_cls  = CLS_LOGIC;
                sc_bw   = 1'b0;
            end
            OP_RSVD: begin sc_lane = dst; sc_cls = CLS_KEEP; sc_wb = 1'b0; end
            default: ;
        endcase
        sc_res = sc_bw ? {dst[WIDTH-1:8], sc_lane[7:0]} : sc_lane;
    end

    // One-bit shift step of the working value; upper byte is untouched in byte mode.
    always_comb begin
        sh_val = work_q;
        sh_c   = (op_q == OP_SHL) ? (bw_q ? work_q[7] : work_q[WIDTH-1]) : work_q[0];
        if (bw_q) begin
            case (op_q)
                OP_SRA:  sh_val[7:0] = {work_q[7], work_q[7:1]};
                OP_RRC:  sh_val[7:0] = {wc_q, work_q[7:1]};
                OP_SHL:  sh_val[7:0] = {work_q[6:0], 1'b0};
                default: ;
            endcase
        end else begin
            case (op_q)
                OP_SRA:  sh_val = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
                OP_RRC:  sh_val = {wc_q, work_q[WIDTH-1:1]};
                OP_SHL:  sh_val = {work_q[WIDTH-2:0], 1'b0};
                default: ;
            endcase
        end
    end

    assign busy      = (state_q == S_BUSY);
    assign fl_res    = busy ? sh_val    : sc_res;
    assign fl_carry  = busy ? sh_c      : sc_carry;
    assign fl_ovf    = busy ? 1'b0      : sc_ovf;
    assign fl_cls    = busy ? CLS_SHIFT : sc_cls;
    assign fl_bw     = busy ? bw_q      : sc_bw;
    assign fl_psw_in = busy ? 4'd0      : psw_in;

    alu_flags #(.WIDTH(WIDTH)) u_flags (
        .res     (fl_res),
        .carry   (fl_carry),
        .ovf     (fl_ovf),
        .cls     (fl_cls),
        .bw      (fl_bw),
        .psw_in  (fl_psw_in),
        .psw_out (fl_psw)
    );

    always_comb begin
        op_d     = op_q;
        bw_d     = bw_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        wc_d     = wc_q;
        result_d = result_q;
        psw_d    = psw_q;
        wb_d     = wb_q;
        if (state_q == S_IDLE && in_valid) begin
            op_d   = op;
            bw_d   = bw;
            cnt_d  = {1'b0, count} + CNT_ONE;
            work_d = dst;
            wc_d   = psw_in[PSW_C];
            if (!is_shift(op)) begin
                result_d = sc_res;
                psw_d    = fl_psw;
                wb_d     = sc_wb;
            end
        end else if (busy) begin
            work_d = sh_val;
            wc_d   = sh_c;
            cnt_d  = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                result_d = sh_val;
                psw_d    = fl_psw;
                wb_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            op_q     <= OP_ADD;
            bw_q     <= 1'b0;
            cnt_q    <= '0;
            work_q   <= '0;
            wc_q     <= 1'b0;
            result_q <= '0;
            psw_q    <= '0;
            wb_q     <= 1'b0;
        end else begin
            op_q     <= op_d;
            bw_q     <= bw_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            wc_q     <= wc_d;
            result_q <= result_d;
            psw_q    <= psw_d;
            wb_q     <= wb_d;
        end
    end

    assign result  = result_q;
    assign psw_out = psw_q;
    assign wb      = wb_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: hand-computed vectors for every opcode class,
// shift latency and saturation, byte mode, backpressure and mid-shift reset.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    logic             Clock = 1'b0;
    logic             Reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       op = 4'h0;
    logic             bw = 1'b0;
    logic [CNT_W-1:0] count = '0;
    logic [WIDTH-1:0] src = '0;
    logic [WIDTH-1:0] dst = '0;
    logic [3:0]       psw_in = 4'h0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic [3:0]       psw_out;
    logic             wb;
    logic [1:0]       state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clock = ~Clock;

    alu_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .bw        (bw),
        .count     (count),
        .src       (src),
        .dst       (dst),
        .psw_in    (psw_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .psw_out   (psw_out),
        .wb        (wb),
        .state_dbg (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts at a falling edge in IDLE; ends at a falling edge back in IDLE.
    task automatic run_op(input string tag, input logic [3:0] o, input logic b,
                          input logic [3:0] c, input logic [15:0] s, input logic [15:0] d,
                          input logic [3:0] p, input int exp_lat, input logic [15:0] exp_res,
                          input logic [3:0] exp_psw, input logic exp_wb);
        int lat;
        check($sformatf("%s_rdy", tag), 32'(in_ready), 32'd1);
        op = o; bw = b; count = c; src = s; dst = d; psw_in = p; in_valid = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            check($sformatf("%s_busy_rdy", tag), 32'(in_ready), 32'd0);
            @(negedge Clock);
            lat++;
        end
        check($sformatf("%s_lat", tag), 32'(lat), 32'(exp_lat));
        check($sformatf("%s_ovld", tag), 32'(out_valid), 32'd1);
        check($sformatf("%s_res", tag), 32'(result), 32'(exp_res));
        check($sformatf("%s_psw", tag), 32'(psw_out), 32'(exp_psw));
        check($sformatf("%s_wb", tag), 32'(wb), 32'(exp_wb));
        out_ready = 1'b1;
        @(negedge Clock);
        out_ready = 1'b0;
        check($sformatf("%s_idle", tag), 32'(state_dbg), 32'(S_IDLE));
        check($sformatf("%s_ovld_lo", tag), 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("rst_rdy", 32'(in_ready), 32'd0);
        check("rst_ovld", 32'(out_valid), 32'd0);
        check("rst_res", 32'(result), 32'd0);
        check("rst_psw", 32'(psw_out), 32'd0);
        check("rst_wb", 32'(wb), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(S_IDLE));
        Reset = 1'b0;
        @(negedge Clock);

        // PSW encoding is {V,N,Z,C}.
        run_op("add_ovf",  OP_ADD,  1'b0, 4'd0,  16'h0001, 16'h7FFF, 4'h0, 1,  16'h8000, 4'hC, 1'b1);
        run_op("cmp_eq",   OP_CMP,  1'b0, 4'd0,  16'h0005, 16'h0005, 4'h0, 1,  16'h0000, 4'h3, 1'b0);
        run_op("addb_c",   OP_ADD,  1'b1, 4'd0,  16'h0001, 16'h12FF, 4'h0, 1,  16'h1200, 4'h3, 1'b1);
        run_op("addb_v",   OP_ADD,  1'b1, 4'd0,  16'h0010, 16'h0070, 4'h0, 1,  16'h0080, 4'hC, 1'b1);
        run_op("rrc3",     OP_RRC,  1'b0, 4'd3,  16'h0000, 16'h0001, 4'h0, 5,  16'h2000, 4'h0, 1'b1);
        run_op("sub_brw",  OP_SUB,  1'b0, 4'd0,  16'h0001, 16'h0000, 4'h0, 1,  16'hFFFF, 4'h4, 1'b1);
        run_op("addc",     OP_ADDC, 1'b0, 4'd0,  16'h0000, 16'hFFFF, 4'h1, 1,  16'h0000, 4'h3, 1'b1);
        run_op("subc",     OP_SUBC, 1'b0, 4'd0,  16'h0003, 16'h0005, 4'h0, 1,  16'h0001, 4'h1, 1'b1);
        run_op("mov",      OP_MOV,  1'b0, 4'd0,  16'hABCD, 16'h0000, 4'hA, 1,  16'hABCD, 4'hA, 1'b1);
        run_op("xor",      OP_XOR,  1'b0, 4'd0,  16'h0FF0, 16'hFF00, 4'hF, 1,  16'hF0F0, 4'h5, 1'b1);
        run_op("bicb",     OP_BIC,  1'b1, 4'd0,  16'h000F, 16'hAAFF, 4'h0, 1,  16'hAAF0, 4'h4, 1'b1);
        run_op("or",       OP_OR,   1'b0, 4'd0,  16'h0000, 16'h0000, 4'h0, 1,  16'h0000, 4'h2, 1'b1);
        run_op("swpb",     OP_SWPB, 1'b1, 4'd0,  16'h0000, 16'h1234, 4'h1, 1,  16'h3412, 4'h1, 1'b1);
        run_op("sxt",      OP_SXT,  1'b1, 4'd0,  16'h0000, 16'h1280, 4'h0, 1,  16'hFF80, 4'h4, 1'b1);
        run_op("rsvd",     OP_RSVD, 1'b0, 4'd0,  16'h1111, 16'h5555, 4'h6, 1,  16'h5555, 4'h6, 1'b0);
        run_op("sra_sat",  OP_SRA,  1'b0, 4'd15, 16'h0000, 16'h8000, 4'h0, 17, 16'hFFFF, 4'h5, 1'b1);
        run_op("shl_zero", OP_SHL,  1'b0, 4'd15, 16'h0000, 16'h0001, 4'h0, 17, 16'h0000, 4'h3, 1'b1);
        run_op("shlb0",    OP_SHL,  1'b1, 4'd0,  16'h0000, 16'hAB80, 4'h0, 2,  16'hAB00, 4'h3, 1'b1);
        run_op("srab2",    OP_SRA,  1'b1, 4'd2,  16'h0000, 16'h0085, 4'h0, 4,  16'h00F0, 4'h5, 1'b1);
        run_op("rrcb0",    OP_RRC,  1'b1, 4'd0,  16'h0000, 16'hFF01, 4'h1, 2,  16'hFF80, 4'h5, 1'b1);

        // Backpressure: result held 3 cycles while a stray request must be ignored.
        op = OP_ADD; bw = 1'b0; count = '0; src = 16'h1111; dst = 16'h1234; psw_in = 4'h0;
        in_valid = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        op = OP_SUB; src = 16'h0001; dst = 16'h0000; psw_in = 4'hF;
        for (int i = 0; i < 3; i++) begin
            check("bp_ovld", 32'(out_valid), 32'd1);
            check("bp_rdy", 32'(in_ready), 32'd0);
            check("bp_res", 32'(result), 32'h2345);
            check("bp_psw", 32'(psw_out), 32'h0);
            @(negedge Clock);
        end
        out_ready = 1'b1;
        @(negedge Clock);
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("bp_idle", 32'(state_dbg), 32'(S_IDLE));
        check("bp_res_keep", 32'(result), 32'h2345);
        check("bp_rdy_back", 32'(in_ready), 32'd1);

        // Reset in the middle of an SHL count=7 aborts it.
        op = OP_SHL; bw = 1'b0; count = 4'd7; src = '0; dst = 16'h0001; psw_in = 4'h0;
        in_valid = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        in_valid = 1'b0;
        check("abort_busy", 32'(state_dbg), 32'(S_BUSY));
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check("abort_state", 32'(state_dbg), 32'(S_IDLE));
        check("abort_ovld", 32'(out_valid), 32'd0);
        check("abort_res", 32'(result), 32'd0);
        check("abort_psw", 32'(psw_out), 32'd0);
        check("abort_wb", 32'(wb), 32'd0);
        check("abort_rdy", 32'(in_ready), 32'd0);
        Reset = 1'b0;
        @(negedge Clock);
        run_op("and_post", OP_AND, 1'b0, 4'd0, 16'h0FF0, 16'hF0F0, 4'h1, 1, 16'h00F0, 4'h1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
